// File: rtl/conv_sequencer_if.sv
// Handshake and MAC-side bus of the convolution sequencer.
// The slave modport is the sequencer's view; the master modport is the view of whoever drives it.
interface conv_sequencer_if #(
    parameter int IDXW = 5
);
    logic            LoadSig;
    logic            LoadKer;
    logic [7:0]      LoadData;
    logic            Start;
    logic            Busy;
    logic            Done;
    logic [7:0]      X;
    logic [7:0]      Y;
    logic            AccumReset;
    logic [31:0]     LocalReg;
    logic [31:0]     Result;
    logic [IDXW-1:0] ResultIdx;
    logic            ResultValid;

    modport slave (
        input  LoadSig, LoadKer, LoadData, Start, LocalReg,
        output Busy, Done, X, Y, AccumReset, Result, ResultIdx, ResultValid
    );

    modport master (
        output LoadSig, LoadKer, LoadData, Start, LocalReg,
        input  Busy, Done, X, Y, AccumReset, Result, ResultIdx, ResultValid
    );
endinterface

// File: rtl/conv_sequencer.sv
// Buffers a signal and a kernel, then drives an external MAC through a full linear
// convolution, capturing one accumulated result per output index.
module conv_sequencer #(
    parameter int SIG_LEN = 16,
    parameter int KER_LEN = 4,
    parameter int IDXW    = 5
) (
    input  logic             Clk,
    input  logic             ResetN,
    conv_sequencer_if.slave  bus
);
    localparam int NOUT = SIG_LEN + KER_LEN - 1;
    localparam int KW   = (KER_LEN > 1) ? $clog2(KER_LEN) : 1;
    localparam int SPW  = (SIG_LEN > 1) ? $clog2(SIG_LEN) : 1;
    localparam int DW   = IDXW + 1;

    typedef enum logic [1:0] {IDLE, MAC, CAPT, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      sig_buf [SIG_LEN];
    logic [7:0]      ker_buf [KER_LEN];
    logic [SPW-1:0]  sig_ptr;
    logic [KW-1:0]   ker_ptr;
    logic [KW-1:0]   k;
    logic [IDXW-1:0] n;
    logic [31:0]     result;
    logic [IDXW-1:0] result_idx;
    logic            result_valid;
    logic            load_ok, last_k, last_n, sig_ok;
    logic [DW-1:0]   sig_pos;
    logic [7:0]      x, y;
    logic            accum_reset;

    assign load_ok = ResetN && (state == IDLE);
    assign last_k  = (k == KW'(KER_LEN - 1));
    assign last_n  = (n == IDXW'(NOUT - 1));

    // One extra bit so n-k underflow shows up as a set sign bit (zero padding on the left).
    assign sig_pos = DW'(n) - DW'(k);
    assign sig_ok  = !sig_pos[DW-1] && (sig_pos < DW'(SIG_LEN));

    // NOTE: storage arrays carry no reset, so they map onto plain registers without reset muxes.
    always_ff @(posedge Clk) begin
        if (load_ok && bus.LoadSig) sig_buf[sig_ptr] <= bus.LoadData;
        if (load_ok && bus.LoadKer) ker_buf[ker_ptr] <= bus.LoadData;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state        <= IDLE;
            n            <= '0;
            k            <= '0;
            sig_ptr      <= '0;
            ker_ptr      <= '0;
            result       <= '0;
            result_idx   <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= 1'b0;
            if (load_ok && bus.LoadSig)
                sig_ptr <= (sig_ptr == SPW'(SIG_LEN - 1)) ? '0 : sig_ptr + SPW'(1);
            if (load_ok && bus.LoadKer)
                ker_ptr <= (ker_ptr == KW'(KER_LEN - 1)) ? '0 : ker_ptr + KW'(1);
            case (state)
                IDLE: if (bus.Start) begin
                    n <= '0;
                    k <= '0;
                end
                MAC:  k <= last_k ? '0 : k + KW'(1);
                CAPT: begin
                    result       <= bus.LocalReg;
                    result_idx   <= n;
                    result_valid <= 1'b1;
                    k            <= '0;
                    if (last_n) begin
                        sig_ptr <= '0;
                        ker_ptr <= '0;
                    end else begin
                        n <= n + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        x           = '0;
        y           = '0;
        accum_reset = 1'b1;
        case (state)
            IDLE: if (bus.Start) state_next = MAC;
            MAC: begin
                accum_reset = 1'b0;
                x           = sig_ok ? sig_buf[sig_pos[SPW-1:0]] : 8'd0;
                y           = ker_buf[k];
                if (last_k) state_next = CAPT;
            end
            CAPT:    state_next = last_n ? DONE : MAC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.Busy        = (state != IDLE);
    assign bus.Done        = (state == DONE);
    assign bus.X           = x;
    assign bus.Y           = y;
    assign bus.AccumReset  = accum_reset;
    assign bus.Result      = result;
    assign bus.ResultIdx   = result_idx;
    assign bus.ResultValid = result_valid;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a table of load/expected-result vectors plus
// hand-written handshake and mid-run reset sequences, with a behavioural MAC attached.
module tb_conv_sequencer;
    localparam int NOUT = 19;

    typedef struct {
        int                nsig;
        logic [16:0][7:0]  sig_wr;
        logic [3:0][7:0]   ker;
        logic [18:0][31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] local_reg = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs [4];

    conv_sequencer_if #(.IDXW(5)) bus ();

    conv_sequencer #(.SIG_LEN(16), .KER_LEN(4), .IDXW(5)) dut (
        .Clk    (clk),
        .ResetN (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: product is combinational, accumulation registered.
    always @(posedge clk)
        local_reg <= bus.AccumReset ? 32'd0 : local_reg + 32'(bus.X) * 32'(bus.Y);
    assign bus.LocalReg = local_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < v.nsig; i++) begin
            @(negedge clk);
            bus.LoadSig  = 1'b1;
            bus.LoadData = v.sig_wr[i];
        end
        @(negedge clk);
        bus.LoadSig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.LoadKer  = 1'b1;
            bus.LoadData = v.ker[i];
        end
        @(negedge clk);
        bus.LoadKer = 1'b0;
    endtask

    // Pulses Start and observes 97 cycles; optionally disturbs the run or checks MAC drive.
    task automatic run_conv(input logic [18:0][31:0] exp, input bit disturb, input bit mac_chk);
        int strobes = 0;
        int dones = 0;
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int c = 0; c <= 96; c++) begin
            if (c > 0) @(negedge clk);
            if (mac_chk && c == 0) begin
                check("mac_c0_x", 32'(bus.X), 32'd1);
                check("mac_c0_y", 32'(bus.Y), 32'd1);
                check("mac_c0_accrst", 32'(bus.AccumReset), 32'd0);
            end
            if (mac_chk && c == 1) begin
                check("mac_c1_x_oob", 32'(bus.X), 32'd0);
                check("mac_c1_y", 32'(bus.Y), 32'd2);
            end
            if (mac_chk && c == 4) begin
                check("capt_accrst", 32'(bus.AccumReset), 32'd1);
                check("capt_x", 32'(bus.X), 32'd0);
            end
            if (bus.ResultValid) begin
                if (strobes < NOUT) begin
                    check("strobe_cycle", 32'(c), 32'((strobes + 1) * 5));
                    check("result_idx", 32'(bus.ResultIdx), 32'(strobes));
                    check("result", bus.Result, exp[strobes]);
                end
                strobes++;
            end
            if (bus.Done) begin
                check("done_cycle", 32'(c), 32'd95);
                dones++;
            end
            if (c == 95) check("busy_in_done", 32'(bus.Busy), 32'd1);
            if (c == 96) check("busy_after_done", 32'(bus.Busy), 32'd0);
            if (disturb && c == 10) begin
                bus.Start    = 1'b1;
                bus.LoadSig  = 1'b1;
                bus.LoadKer  = 1'b1;
                bus.LoadData = 8'hAA;
            end
            if (disturb && c == 11) begin
                bus.Start   = 1'b0;
                bus.LoadSig = 1'b0;
                bus.LoadKer = 1'b0;
            end
        end
        check("strobe_count", 32'(strobes), 32'(NOUT));
        check("done_count", 32'(dones), 32'd1);
        check("result_hold", bus.Result, exp[18]);
        check("result_idx_hold", 32'(bus.ResultIdx), 32'd18);
    endtask

    initial begin
        // Ramp: sig all 1, ker {1,2,3,4}
        vecs[0].nsig = 16;
        vecs[0].sig_wr = '0;
        for (int i = 0; i < 16; i++) vecs[0].sig_wr[i] = 8'd1;
        vecs[0].ker = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < NOUT; i++) vecs[0].exp[i] = 32'd10;
        vecs[0].exp[0] = 32'd1;  vecs[0].exp[1] = 32'd3;  vecs[0].exp[2] = 32'd6;
        vecs[0].exp[16] = 32'd9; vecs[0].exp[17] = 32'd7; vecs[0].exp[18] = 32'd4;

        // Impulse at sig[5], ker {7,0,0,9}
        vecs[1].nsig = 16;
        vecs[1].sig_wr = '0;
        vecs[1].sig_wr[5] = 8'd1;
        vecs[1].ker = {8'd9, 8'd0, 8'd0, 8'd7};
        vecs[1].exp = '0;
        vecs[1].exp[5] = 32'd7;
        vecs[1].exp[8] = 32'd9;

        // Max values
        vecs[2].nsig = 16;
        vecs[2].sig_wr = '0;
        for (int i = 0; i < 16; i++) vecs[2].sig_wr[i] = 8'd255;
        vecs[2].ker = {8'd255, 8'd255, 8'd255, 8'd255};
        for (int i = 0; i < NOUT; i++) vecs[2].exp[i] = 32'd260100;
        vecs[2].exp[0] = 32'd65025;   vecs[2].exp[1] = 32'd130050;  vecs[2].exp[2] = 32'd195075;
        vecs[2].exp[16] = 32'd195075; vecs[2].exp[17] = 32'd130050; vecs[2].exp[18] = 32'd65025;

        // Pointer wrap: 17 writes 1..17 leave sig = {17,2..16}; ker {1,0,0,0} echoes sig
        vecs[3].nsig = 17;
        for (int i = 0; i < 17; i++) vecs[3].sig_wr[i] = 8'(i + 1);
        vecs[3].ker = {8'd0, 8'd0, 8'd0, 8'd1};
        vecs[3].exp = '0;
        vecs[3].exp[0] = 32'd17;
        for (int i = 1; i < 16; i++) vecs[3].exp[i] = 32'(i + 1);

        rst_n        = 1'b0;
        bus.LoadSig  = 1'b0;
        bus.LoadKer  = 1'b0;
        bus.LoadData = 8'd0;
        bus.Start    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_x", 32'(bus.X), 32'd0);
        check("rst_y", 32'(bus.Y), 32'd0);
        check("rst_accrst", 32'(bus.AccumReset), 32'd1);
        check("rst_result", bus.Result, 32'd0);
        check("rst_result_idx", 32'(bus.ResultIdx), 32'd0);
        check("rst_valid", 32'(bus.ResultValid), 32'd0);
        rst_n = 1'b1;

        // Ramp clean, then ramp with Start/Load pulses mid-run
        load_vec(vecs[0]);
        run_conv(vecs[0].exp, 1'b0, 1'b1);
        run_conv(vecs[0].exp, 1'b1, 1'b0);

        // Reset during MAC of output 4 (cycles 20..23)
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (21) @(negedge clk);
        check("pre_abort_busy", 32'(bus.Busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_accrst", 32'(bus.AccumReset), 32'd1);
        check("abort_valid", 32'(bus.ResultValid), 32'd0);
        check("abort_result", bus.Result, 32'd0);
        rst_n = 1'b1;
        run_conv(vecs[0].exp, 1'b0, 1'b0);

        for (int v = 1; v < 4; v++) begin
            load_vec(vecs[v]);
            run_conv(vecs[v].exp, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Upstream control stage for the multiply-accumulate datapath. It buffers a signal vector and a kernel, then performs a full linear convolution. For each output it drives the sample/coefficient pairs into the MAC's `x`/`y` inputs and sequences the MAC's `AccumReset`. It captures the MAC's 32-bit `LocalReg` into an indexed result stream with a one-cycle valid strobe.

## Interface
- `SIG_LEN`, 16: signal samples held in the internal buffer.
- `KER_LEN`, 4: kernel taps held in the internal buffer.
- `IDXW`, 5: width of `ResultIdx`. Must hold `SIG_LEN+KER_LEN-2`.
- `Clk` in 1: the block's only clock. All state updates on the rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `LoadSig` in 1: write `LoadData` to the signal buffer at the signal write pointer.
- `LoadKer` in 1: write `LoadData` to the kernel buffer at the kernel write pointer.
- `LoadData` in 8: unsigned sample or coefficient.
- `Start` in 1: begin convolution. Sampled only in IDLE.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse after the last result.
- `X` out 8: to MAC `x`.
- `Y` out 8: to MAC `y`.
- `AccumReset` out 1: to MAC `AccumReset`. Active high, clears `LocalReg` at the clock edge.
- `LocalReg` in 32: running sum from the MAC.
- `Result` out 32: captured convolution output.
- `ResultIdx` out IDXW: output index n of `Result`.
- `ResultValid` out 1: one-cycle strobe; `Result` and `ResultIdx` are valid while it is high.

## Operation
- MAC contract: each rising edge, `LocalReg <= AccumReset ? 0 : LocalReg + X*Y`. The product is combinational, with zero added latency.
- `NOUT = SIG_LEN+KER_LEN-1`. Output n is the sum over k=0..KER_LEN-1 of `sig[n-k]*ker[k]`.
- `sig[i]` is read as 0 when i<0 or i≥SIG_LEN. Every output always takes exactly KER_LEN MAC cycles.
- Arithmetic is unsigned. 8x8 gives a 16-bit product, accumulated in 32 bits; overflow is impossible for legal parameters.
- Buffers are register arrays with asynchronous read. Each write pointer auto-increments and wraps to 0 after the last entry.
- `LoadSig` and `LoadKer` in the same cycle write `LoadData` into both buffers.
- Loads are honoured only in IDLE; they are ignored while `Busy`. Write pointers return to 0 on reset and on entry to DONE.
- A load in the same cycle as `Start` is written, and the computation sees the new value.
- Buffer contents are not cleared by reset.
- State machine:
  - IDLE: `AccumReset`=1, `X`=`Y`=0. On `Start`, clear n and k and go to MAC.
  - MAC: `AccumReset`=0, `X`=`sig[n-k]` (or 0 when out of range), `Y`=`ker[k]`. Increment k; after k=KER_LEN-1, go to CAPT.
  - CAPT: `AccumReset`=1, `X`=`Y`=0. At the edge, register `Result<=LocalReg`, `ResultIdx<=n`, `ResultValid<=1`, and clear k. If n=NOUT-1 go to DONE; otherwise increment n and go to MAC.
  - DONE: `Done`=1 for one cycle, then go to IDLE.
- `Start` outside IDLE is ignored.
- `ResultValid` is a registered one-cycle pulse. `Result` and `ResultIdx` hold their value until the next capture.

## Timing
- Reset values: `Busy` 0, `Done` 0, `X` 0, `Y` 0, `AccumReset` 1, `Result` 0, `ResultIdx` 0, `ResultValid` 0. State goes to IDLE; n, k and both write pointers go to 0.
- `Busy`, `Done`, `X`, `Y` and `AccumReset` are Moore decodes of registered state, counters and buffers.
- Cycle numbering: the `Start` edge is E0, and cycle 0 is the first cycle after E0.
  - MAC for output n occupies cycles n·(K+1) .. n·(K+1)+K-1, where K = KER_LEN.
  - CAPT for output n is cycle n·(K+1)+K.
  - `ResultValid` for output n is high in cycle (n+1)·(K+1).
- The last `ResultValid` coincides with the DONE cycle (`Done`=1, `Busy`=1). `Busy` falls the next cycle.
- Default parameters: 19 outputs × 5 cycles = 95 busy cycles plus 1 DONE cycle.
- Reset asserted mid-operation: at the next edge every output takes its reset value. The MAC is held clear because `AccumReset`=1, and no partial `ResultValid` is issued.

## Test plan
- Ramp: load sig all 1 and ker {1,2,3,4}, then pulse Start. Required `Result` sequence by idx 0..18: 1, 3, 6, then 10 for idx 3..15, then 9, 7, 4. Exactly 19 strobes, spaced 5 cycles apart.
- Impulse: load sig[5]=1 (others 0) and ker {7,0,0,9}. Required idx5 = 7, idx8 = 9, all other outputs 0.
- Max values: sig and ker all 255. Required idx3..15 = 260100 (0x3F804) and idx0 = 65025.
- Handshake: pulse Start while Busy, and pulse LoadSig with data 0xAA mid-run. Required: no restart, buffers unchanged, `Done` exactly once in cycle 95, `Busy` 0 in cycle 96.
- Reset mid-run: drop ResetN during MAC of output 4. Required: next cycle `Busy`=0, `AccumReset`=1, `ResultValid`=0. A restart without reloading reproduces the ramp results exactly.
- Pointer wrap: 17 LoadSig writes with values 1..17. Required: sig[0]=17, sig[1..15]=2..16, and the following convolution reflects those contents.
